hack_alu_sequencer: RTL and testbench
=====================================

Name: hack_alu_sequencer

Overview:
- Initiator side of the ALU ce/rd_rdy handshake.
- Accepts Hack instructions over a valid/ready port and executes them:
  - A-instructions load A directly.
  - C-instructions are decoded into ALU operand and control bits, issued with a one-cycle ce pulse, and completed when the ALU returns rd_rdy.
- On completion it updates the A/D registers, evaluates the jump condition, and presents a result on a second valid/ready port.
- Sits between instruction fetch and the ALU in the Nand2Tetris core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before the operation is aborted (range 1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE
- instr  in  16  Hack instruction word
- m_in  in  16  M operand; sampled together with instr at accept
- alu_x  out  16  ALU x operand (D)
- alu_y  out  16  ALU y operand (A or M)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_ce  out  1  issue strobe
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU flags
- alu_rd_rdy  in  1  ALU result valid
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_out  out  16  captured result
- res_zr, res_ng  out  1 each  captured flags
- res_jump  out  1  jump taken
- res_write_m  out  1  dest includes M
- a_reg, d_reg  out  16 each  architectural A and D registers
- timeout_err  out  1  sticky; cleared only by reset
- chk_err  out  1  sticky; see Optional Feature

Behaviour:
- Clock and reset: single clock domain, one clock. reset is synchronous and active-high.
  - On reset every output and internal register goes to 0; state goes to IDLE, so instr_ready = 1 in the first cycle after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr and m_in.
  - instr[15] = 0 (A-instruction): A <= instr; go to DONE with res_out = instr, flags = 0, res_jump = 0, res_write_m = 0. No ALU activity.
  - instr[15] = 1 (C-instruction): go to ISSUE.
- C-instruction decode:
  - a = instr[12]; {zx,nx,zy,ny,f,no} = instr[11:6]; dest {A,D,M} = instr[5:3]; jump {lt,eq,gt} = instr[2:0].
  - alu_x = D and alu_y = (a ? latched m_in : A), using register values as of the accept cycle.
  - Operands and control bits are held stable from ISSUE through the end of WAIT. They are 0 in all other states.
- ISSUE: alu_ce = 1 for exactly this cycle; go to WAIT unconditionally. alu_rd_rdy is ignored in ISSUE.
- WAIT: sample alu_rd_rdy every cycle.
  - When it is 1: capture alu_out, alu_zr, alu_ng into res_*.
    - If dest A, A <= alu_out; if dest D, D <= alu_out; both may update in the same edge.
    - res_write_m = dest M; res_jump = (lt & ng) | (eq & zr) | (gt & ~zr & ~ng).
    - Go to DONE.
  - The wait counter increments every WAIT cycle without rd_rdy. When it reaches TIMEOUT_CYCLES:
    - set timeout_err and go to DONE;
    - res_out, res_zr, res_ng, res_jump, res_write_m = 0;
    - A and D are unchanged.
- DONE: res_valid = 1; res_* are held stable until res_ready. On res_valid & res_ready, go to IDLE and deassert res_valid.
- Latency: a C-instruction accepted at cycle t has alu_ce at t+1. With rd_rdy at t+2, res_valid is first high at t+3.
- Spurious rd_rdy in IDLE, ISSUE or DONE is ignored, including a late rd_rdy after a timeout or after reset.
- Reset mid-operation: the operation is abandoned with no register writes; alu_ce and res_valid are 0 after the reset edge.

Optional Feature:
- Macro ALU_CHECK_EN.
- Defined: an internal combinational Hack ALU model computes the expected out, zr and ng from the issued operands and controls. On rd_rdy capture, any mismatch sets chk_err (sticky until reset). Capture and register writes proceed with the responder's values.
- Undefined: no model is built; chk_err is tied to 0.

Test Plan:
1. After reset, A-instr 0x0005 → no alu_ce pulse; res_valid with res_out = 0x0005; a_reg = 0x0005 after the handshake.
2. A = 5, C-instr 0xEC10 (D=A); model ALU returns 5 two cycles after ce → one-cycle ce pulse; controls = 110000; alu_y = 5; d_reg = 5; res_jump = 0.
3. D = 5, C-instr 0xE301 (D;JGT); ALU returns out = 5, zr = 0, ng = 0 → res_jump = 1; a_reg and d_reg unchanged.
4. C-instr 0xFC08 (M=M) with m_in = 0x1234 → alu_y = 0x1234; res_write_m = 1; res_out = 0x1234; a_reg and d_reg unchanged.
5. TIMEOUT_CYCLES = 4; responder never asserts rd_rdy → DONE after 4 WAIT cycles; timeout_err = 1; res_out = 0; d_reg unchanged. A later rd_rdy pulse is ignored.
6. Hold res_ready = 0 for 10 cycles → res_* stable and instr_ready = 0 throughout. Then assert reset in WAIT of a new op → next cycle instr_ready = 1, alu_ce = 0, and a late rd_rdy causes no register change.

Source files
------------

// File: rtl/hack_alu_sequencer.sv
// hack_alu_sequencer: accepts Hack instructions on a valid/ready port, loads A
// directly for A-instructions, and for C-instructions issues operands/controls to
// the ALU with a one-cycle ce strobe, waits for rd_rdy (bounded by TIMEOUT_CYCLES),
// then updates A/D, evaluates the jump and presents the result on a second
// valid/ready port.
// Optional build macro ALU_CHECK_EN: adds an internal Hack ALU model that flags
// responder results which disagree with it on the sticky chk_err output.
module hack_alu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] m_in,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    output logic        alu_ce,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    input  logic        alu_rd_rdy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_out,
    output logic        res_zr,
    output logic        res_ng,
    output logic        res_jump,
    output logic        res_write_m,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        timeout_err,
    output logic        chk_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last WAIT-cycle count value before the operation is abandoned.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    // Decoded C-instruction fields and operands, frozen at accept.
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [5:0]  ctrl_q;
    logic [2:0]  dest_q;
    logic [2:0]  jump_q;
    logic [15:0] wait_cnt;

    logic        accept;
    logic        rd_hit;
    logic        timeout_hit;
    logic        operands_on;
    logic        jump_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, handshake strobes and ALU-facing outputs.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        alu_ce      = 1'b0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        rd_hit      = 1'b0;
        timeout_hit = 1'b0;
        operands_on = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = instr[15] ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                alu_ce      = 1'b1;
                operands_on = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                operands_on = 1'b1;
                if (alu_rd_rdy) begin
                    rd_hit     = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands and controls are driven only while an operation is in flight.
    always_comb begin
        alu_x = '0;
        alu_y = '0;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
        if (operands_on) begin
            alu_x = x_q;
            alu_y = y_q;
            {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl_q;
        end
    end

    // Jump condition from the flags the ALU returns with rd_rdy.
    always_comb begin
        jump_hit = (jump_q[2] & alu_ng) |
                   (jump_q[1] & alu_zr) |
                   (jump_q[0] & ~alu_zr & ~alu_ng);
    end

    // Datapath: instruction latch, wait counter, A/D writes and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            ctrl_q      <= '0;
            dest_q      <= '0;
            jump_q      <= '0;
            wait_cnt    <= '0;
            a_reg       <= '0;
            d_reg       <= '0;
            res_out     <= '0;
            res_zr      <= 1'b0;
            res_ng      <= 1'b0;
            res_jump    <= 1'b0;
            res_write_m <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                // Operands use A/D as they stand in the accept cycle.
                x_q      <= d_reg;
                y_q      <= instr[12] ? m_in : a_reg;
                ctrl_q   <= instr[11:6];
                dest_q   <= instr[5:3];
                jump_q   <= instr[2:0];
                wait_cnt <= '0;
                if (!instr[15]) begin
                    a_reg       <= instr;
                    res_out     <= instr;
                    res_zr      <= 1'b0;
                    res_ng      <= 1'b0;
                    res_jump    <= 1'b0;
                    res_write_m <= 1'b0;
                end
            end

            if (state == WAIT && !alu_rd_rdy && !timeout_hit) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (rd_hit) begin
                res_out     <= alu_out;
                res_zr      <= alu_zr;
                res_ng      <= alu_ng;
                res_jump    <= jump_hit;
                res_write_m <= dest_q[0];
                if (dest_q[2]) begin
                    a_reg <= alu_out;
                end
                if (dest_q[1]) begin
                    d_reg <= alu_out;
                end
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
                res_out     <= '0;
                res_zr      <= 1'b0;
                res_ng      <= 1'b0;
                res_jump    <= 1'b0;
                res_write_m <= 1'b0;
            end
        end
    end

`ifdef ALU_CHECK_EN
    logic [15:0] mx_z;
    logic [15:0] mx_n;
    logic [15:0] my_z;
    logic [15:0] my_n;
    logic [15:0] m_fn;
    logic [15:0] model_out;
    logic        model_zr;
    logic        model_ng;

    // Reference Hack ALU evaluated on the issued operands and controls.
    always_comb begin
        mx_z      = ctrl_q[5] ? 16'h0000 : x_q;
        mx_n      = ctrl_q[4] ? ~mx_z : mx_z;
        my_z      = ctrl_q[3] ? 16'h0000 : y_q;
        my_n      = ctrl_q[2] ? ~my_z : my_z;
        m_fn      = ctrl_q[1] ? (mx_n + my_n) : (mx_n & my_n);
        model_out = ctrl_q[0] ? ~m_fn : m_fn;
        model_zr  = (model_out == 16'h0000);
        model_ng  = model_out[15];
    end

    // Sticky flag for any responder result that disagrees with the model.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err <= 1'b0;
        end else if (rd_hit && ((alu_out != model_out) ||
                                (alu_zr != model_zr) ||
                                (alu_ng != model_ng))) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_alu_sequencer.sv
// Directed testbench for hack_alu_sequencer: reset state, A-instruction, C-instruction
// with D/JGT/M destinations, timeout abort, result back-pressure and mid-op reset.
module tb_hack_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] m_in;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_ce;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        alu_rd_rdy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_out;
    logic        res_zr;
    logic        res_ng;
    logic        res_jump;
    logic        res_write_m;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        timeout_err;
    logic        chk_err;

    logic [5:0]  ctrl;
    int          checks;
    int          errors;
    int          ce_count;

    assign ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

    hack_alu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .m_in        (m_in),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_zx      (alu_zx),
        .alu_nx      (alu_nx),
        .alu_zy      (alu_zy),
        .alu_ny      (alu_ny),
        .alu_f       (alu_f),
        .alu_no      (alu_no),
        .alu_ce      (alu_ce),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .alu_rd_rdy  (alu_rd_rdy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_out     (res_out),
        .res_zr      (res_zr),
        .res_ng      (res_ng),
        .res_jump    (res_jump),
        .res_write_m (res_write_m),
        .a_reg       (a_reg),
        .d_reg       (d_reg),
        .timeout_err (timeout_err),
        .chk_err     (chk_err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count ce strobes mid-cycle, away from the active edge.
    initial ce_count = 0;
    always @(negedge clk) begin
        if (alu_ce === 1'b1) ce_count++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_result;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        instr_valid = 1'b0; instr = '0; m_in = '0;
        alu_out = '0; alu_zr = 1'b0; alu_ng = 1'b0; alu_rd_rdy = 1'b0;
        res_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %0b want 1", instr_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if (alu_ce !== 1'b0) begin errors++; $display("FAIL reset_alu_ce got %0b want 0", alu_ce); end
        checks++; if (a_reg !== 16'h0000 || d_reg !== 16'h0000) begin errors++; $display("FAIL reset_ad got a=%h d=%h want 0000/0000", a_reg, d_reg); end
        checks++; if (res_out !== 16'h0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_res got res_out=%h terr=%0b want 0000/0", res_out, timeout_err); end
        checks++; if (alu_x !== 16'h0000 || alu_y !== 16'h0000 || ctrl !== 6'b000000) begin errors++; $display("FAIL reset_alu_ops got x=%h y=%h ctrl=%b want zeros", alu_x, alu_y, ctrl); end
    endtask

    task automatic test_a_instr;
        int ce0;
        ce0 = ce_count;
        instr = 16'h0005; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_out !== 16'h0005) begin errors++; $display("FAIL a_instr_result got valid=%0b out=%h want 1/0005", res_valid, res_out); end
        checks++; if (res_jump !== 1'b0 || res_write_m !== 1'b0 || res_zr !== 1'b0 || res_ng !== 1'b0) begin errors++; $display("FAIL a_instr_flags got j=%0b m=%0b zr=%0b ng=%0b want 0000", res_jump, res_write_m, res_zr, res_ng); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL a_instr_ready got %0b want 0", instr_ready); end
        release_result();
        checks++; if (a_reg !== 16'h0005) begin errors++; $display("FAIL a_instr_areg got %h want 0005", a_reg); end
        checks++; if (ce_count != ce0) begin errors++; $display("FAIL a_instr_no_ce got %0d pulses want 0", ce_count - ce0); end
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL a_instr_idle got valid=%0b ready=%0b want 0/1", res_valid, instr_ready); end
    endtask

    task automatic test_c_dest_d;
        int ce0;
        ce0 = ce_count;
        instr = 16'hEC10; m_in = 16'h0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (alu_ce !== 1'b1) begin errors++; $display("FAIL dd_ce got %0b want 1", alu_ce); end
        checks++; if (ctrl !== 6'b110000) begin errors++; $display("FAIL dd_ctrl got %b want 110000", ctrl); end
        checks++; if (alu_y !== 16'h0005 || alu_x !== 16'h0000) begin errors++; $display("FAIL dd_ops got x=%h y=%h want 0000/0005", alu_x, alu_y); end
        tick();
        checks++; if (alu_ce !== 1'b0 || ctrl !== 6'b110000 || alu_y !== 16'h0005) begin errors++; $display("FAIL dd_wait_hold got ce=%0b ctrl=%b y=%h want 0/110000/0005", alu_ce, ctrl, alu_y); end
        tick();
        alu_rd_rdy = 1'b1; alu_out = 16'h0005; alu_zr = 1'b0; alu_ng = 1'b0;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000;
        checks++; if (res_valid !== 1'b1 || res_out !== 16'h0005) begin errors++; $display("FAIL dd_result got valid=%0b out=%h want 1/0005", res_valid, res_out); end
        checks++; if (d_reg !== 16'h0005 || a_reg !== 16'h0005) begin errors++; $display("FAIL dd_regs got a=%h d=%h want 0005/0005", a_reg, d_reg); end
        checks++; if (res_jump !== 1'b0 || res_write_m !== 1'b0) begin errors++; $display("FAIL dd_jump_m got j=%0b m=%0b want 0/0", res_jump, res_write_m); end
        checks++; if (alu_y !== 16'h0000 || ctrl !== 6'b000000) begin errors++; $display("FAIL dd_done_ops got y=%h ctrl=%b want 0000/000000", alu_y, ctrl); end
        checks++; if (ce_count - ce0 != 1) begin errors++; $display("FAIL dd_ce_count got %0d want 1", ce_count - ce0); end
        release_result();
    endtask

    task automatic test_c_jump;
        instr = 16'hE301; m_in = 16'h0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (alu_ce !== 1'b1 || alu_x !== 16'h0005 || ctrl !== 6'b001100) begin errors++; $display("FAIL jgt_issue got ce=%0b x=%h ctrl=%b want 1/0005/001100", alu_ce, alu_x, ctrl); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL jgt_early_valid got %0b want 0", res_valid); end
        alu_rd_rdy = 1'b1; alu_out = 16'h0005; alu_zr = 1'b0; alu_ng = 1'b0;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000;
        checks++; if (res_valid !== 1'b1 || res_jump !== 1'b1) begin errors++; $display("FAIL jgt_result got valid=%0b jump=%0b want 1/1", res_valid, res_jump); end
        checks++; if (a_reg !== 16'h0005 || d_reg !== 16'h0005 || res_write_m !== 1'b0) begin errors++; $display("FAIL jgt_regs got a=%h d=%h m=%0b want 0005/0005/0", a_reg, d_reg, res_write_m); end
        release_result();
    endtask

    task automatic test_c_write_m;
        instr = 16'hFC08; m_in = 16'h1234; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; m_in = 16'h0000;
        checks++; if (alu_y !== 16'h1234 || ctrl !== 6'b110000) begin errors++; $display("FAIL wm_issue got y=%h ctrl=%b want 1234/110000", alu_y, ctrl); end
        tick();
        checks++; if (alu_y !== 16'h1234) begin errors++; $display("FAIL wm_latched_m got y=%h want 1234", alu_y); end
        alu_rd_rdy = 1'b1; alu_out = 16'h1234; alu_zr = 1'b0; alu_ng = 1'b0;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000;
        checks++; if (res_write_m !== 1'b1 || res_out !== 16'h1234 || res_jump !== 1'b0) begin errors++; $display("FAIL wm_result got m=%0b out=%h j=%0b want 1/1234/0", res_write_m, res_out, res_jump); end
        checks++; if (a_reg !== 16'h0005 || d_reg !== 16'h0005) begin errors++; $display("FAIL wm_regs got a=%h d=%h want 0005/0005", a_reg, d_reg); end
        release_result();
    endtask

    task automatic test_timeout;
        instr = 16'hEC10; m_in = 16'h0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (res_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait4 got valid=%0b terr=%0b want 0/0", res_valid, timeout_err); end
        tick();
        checks++; if (res_valid !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_done got valid=%0b terr=%0b want 1/1", res_valid, timeout_err); end
        checks++; if (res_out !== 16'h0000 || res_jump !== 1'b0 || res_write_m !== 1'b0) begin errors++; $display("FAIL to_result got out=%h j=%0b m=%0b want 0000/0/0", res_out, res_jump, res_write_m); end
        checks++; if (d_reg !== 16'h0005 || a_reg !== 16'h0005) begin errors++; $display("FAIL to_regs got a=%h d=%h want 0005/0005", a_reg, d_reg); end
        alu_rd_rdy = 1'b1; alu_out = 16'hBEEF; alu_zr = 1'b0; alu_ng = 1'b1;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000; alu_ng = 1'b0;
        checks++; if (res_out !== 16'h0000 || d_reg !== 16'h0005 || res_valid !== 1'b1) begin errors++; $display("FAIL to_late_rdy got out=%h d=%h valid=%0b want 0000/0005/1", res_out, d_reg, res_valid); end
        release_result();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", timeout_err); end
    endtask

    task automatic test_back_to_back;
        instr = 16'hE301; m_in = 16'h0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        alu_rd_rdy = 1'b1; alu_out = 16'h0005; alu_zr = 1'b0; alu_ng = 1'b0;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000;
        // Offer an A-instruction while the result is held; it must not be taken.
        instr = 16'h0042; instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_out !== 16'h0005 || res_jump !== 1'b1 || instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%0b out=%h j=%0b ready=%0b want 1/0005/1/0", i, res_valid, res_out, res_jump, instr_ready);
            end
            tick();
        end
        instr_valid = 1'b0;
        release_result();
        checks++; if (a_reg !== 16'h0005 || instr_ready !== 1'b1) begin errors++; $display("FAIL hold_release got a=%h ready=%0b want 0005/1", a_reg, instr_ready); end

        instr = 16'hEC10; m_in = 16'h0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1 || alu_ce !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL midreset_ctl got ready=%0b ce=%0b valid=%0b want 1/0/0", instr_ready, alu_ce, res_valid); end
        checks++; if (a_reg !== 16'h0000 || d_reg !== 16'h0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL midreset_regs got a=%h d=%h terr=%0b want 0000/0000/0", a_reg, d_reg, timeout_err); end
        alu_rd_rdy = 1'b1; alu_out = 16'h9999; alu_zr = 1'b0; alu_ng = 1'b1;
        tick();
        alu_rd_rdy = 1'b0; alu_out = 16'h0000; alu_ng = 1'b0;
        checks++; if (a_reg !== 16'h0000 || d_reg !== 16'h0000 || res_valid !== 1'b0 || res_out !== 16'h0000) begin errors++; $display("FAIL midreset_late_rdy got a=%h d=%h valid=%0b out=%h want 0000/0000/0/0000", a_reg, d_reg, res_valid, res_out); end
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_err got %0b want 0", chk_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_a_instr();
        test_c_dest_d();
        test_c_jump();
        test_c_write_m();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
